// File: rtl/ahb_slave_arbiter.sv
// Round-robin arbiter placing several AHB masters onto one slave port.
// The address phase follows grant and HWDATA follows resp_sel, so a handover can pipeline.
module ahb_slave_arbiter #(
  parameter int unsigned CHANNEL_NUM = 2,
  parameter int unsigned PAY_LOAD    = 78
) (
  input  logic                                HCLK,
  input  logic                                HRESETn,
  input  logic [CHANNEL_NUM-1:0][PAY_LOAD-1:0] payload_in,
  input  logic [CHANNEL_NUM-1:0]              req,
  input  logic                                hreadyout,
  output logic [PAY_LOAD-1:0]                 payload_out,
  output logic                                hsel_out,
  output logic [CHANNEL_NUM-1:0]              grant,
  output logic [CHANNEL_NUM-1:0]              resp_sel
);

  localparam int unsigned IdxW = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;

  typedef enum logic {StIdle, StOwn} state_e;

  state_e                 r_state, w_state_d;
  logic [CHANNEL_NUM-1:0] r_grant, w_grant_d;
  logic [CHANNEL_NUM-1:0] r_resp_sel, w_resp_sel_d;
  logic [IdxW-1:0]        r_ptr, w_ptr_d;
  logic [IdxW-1:0]        w_owner, w_resp_idx, w_next_idx, w_cand;
  logic                   w_found, w_lock;
  logic [PAY_LOAD-1:0]    w_own_pl;
  logic [31:0]            w_resp_wdata;
  logic [1:0]             w_htrans;

  always_comb begin
    w_owner    = '0;
    w_resp_idx = '0;
    for (int unsigned i = 0; i < CHANNEL_NUM; i++) begin
      if (r_grant[i])    w_owner    = IdxW'(i);
      if (r_resp_sel[i]) w_resp_idx = IdxW'(i);
    end
  end

  always_comb begin
    w_own_pl     = (|r_grant) ? payload_in[w_owner] : '0;
    w_resp_wdata = (|r_resp_sel) ? payload_in[w_resp_idx][45:14] : '0;
    w_htrans     = w_own_pl[13:12];
    // BUSY and SEQ both have HTRANS[0] set
    w_lock       = (|r_grant) && (w_htrans[0] || w_own_pl[0]);
    hsel_out     = (|r_grant) && req[w_owner];
    payload_out  = w_own_pl;
    payload_out[45:14] = w_resp_wdata;
  end

  // Search starts just after the last owner, so the current owner is visited last.
  always_comb begin
    w_found    = 1'b0;
    w_next_idx = r_ptr;
    w_cand     = '0;
    for (int unsigned k = 1; k <= CHANNEL_NUM; k++) begin
      w_cand = IdxW'((32'(r_ptr) + k) % CHANNEL_NUM);
      if (!w_found && req[w_cand]) begin
        w_found    = 1'b1;
        w_next_idx = w_cand;
      end
    end
  end

  always_comb begin
    w_grant_d    = r_grant;
    w_resp_sel_d = r_resp_sel;
    w_ptr_d      = r_ptr;
    if (hreadyout) begin
      w_resp_sel_d = (hsel_out && w_htrans[1]) ? r_grant : '0;
      if (!w_lock) begin
        if (w_found) begin
          w_grant_d = CHANNEL_NUM'(1) << w_next_idx;
          w_ptr_d   = w_next_idx;
        end else begin
          w_grant_d = '0;
        end
      end
    end
    w_state_d = (|w_grant_d) ? StOwn : StIdle;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state    <= StIdle;
      r_grant    <= '0;
      r_resp_sel <= '0;
      r_ptr      <= IdxW'(CHANNEL_NUM - 1);
    end else begin
      r_state    <= w_state_d;
      r_grant    <= w_grant_d;
      r_resp_sel <= w_resp_sel_d;
      r_ptr      <= w_ptr_d;
    end
  end

  assign grant    = (r_state == StOwn) ? r_grant : '0;
  assign resp_sel = r_resp_sel;

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// Directed bench for ahb_slave_arbiter: single, contention, locked burst with waits,
// reset mid-burst and idle release.
module tb_ahb_slave_arbiter;

  localparam logic [1:0] TrIdle = 2'b00;
  localparam logic [1:0] TrNseq = 2'b10;
  localparam logic [1:0] TrSeq  = 2'b11;

  logic            HCLK = 1'b0;
  logic            HRESETn;
  logic [1:0][77:0] payload_in;
  logic [1:0]      req;
  logic            hreadyout;
  logic [77:0]     payload_out;
  logic            hsel_out;
  logic [1:0]      grant;
  logic [1:0]      resp_sel;

  int n_pass  = 0;
  int n_total = 0;

  ahb_slave_arbiter #(.CHANNEL_NUM(2), .PAY_LOAD(78)) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .payload_in  (payload_in),
    .req         (req),
    .hreadyout   (hreadyout),
    .payload_out (payload_out),
    .hsel_out    (hsel_out),
    .grant       (grant),
    .resp_sel    (resp_sel)
  );

  always #5 HCLK = ~HCLK;

  function automatic logic [77:0] mk(input logic [31:0] addr, input logic [31:0] wdata,
                                     input logic [1:0] htrans, input logic lock);
    return {addr, wdata, htrans, 3'b011, 3'b010, 1'b1, 4'b0011, lock};
  endfunction

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic do_reset();
    HRESETn    = 1'b0;
    req        = '0;
    payload_in = '0;
    hreadyout  = 1'b1;
    tick();
    HRESETn = 1'b1;
  endtask

  task automatic test_reset();
    HRESETn       = 1'b0;
    hreadyout     = 1'b1;
    payload_in    = '0;
    payload_in[0] = mk(32'h0000_0040, 32'h1111_2222, TrNseq, 1'b0);
    req           = 2'b01;
    #2;
    n_total++; if (grant !== 2'b00) $display("FAIL reset_grant got %b want 00", grant);
    else n_pass++;
    n_total++; if (resp_sel !== 2'b00) $display("FAIL reset_resp_sel got %b want 00", resp_sel);
    else n_pass++;
    n_total++; if (payload_out !== 78'd0) $display("FAIL reset_payload got %h want 0", payload_out);
    else n_pass++;
    n_total++; if (hsel_out !== 1'b0) $display("FAIL reset_hsel got %b want 0", hsel_out);
    else n_pass++;
    tick();
    n_total++; if (grant !== 2'b00) $display("FAIL reset_hold_grant got %b want 00", grant);
    else n_pass++;
  endtask

  task automatic test_single();
    do_reset();
    payload_in[0] = mk(32'h0000_1000, 32'hA5A5_0001, TrNseq, 1'b0);
    req = 2'b01;
    #1;
    n_total++; if (grant !== 2'b00) $display("FAIL single_pre_grant got %b want 00", grant);
    else n_pass++;
    tick();
    n_total++; if (grant !== 2'b01) $display("FAIL single_grant got %b want 01", grant);
    else n_pass++;
    n_total++; if (hsel_out !== 1'b1) $display("FAIL single_hsel got %b want 1", hsel_out);
    else n_pass++;
    n_total++; if (payload_out[77:46] !== 32'h0000_1000)
      $display("FAIL single_haddr got %h want 00001000", payload_out[77:46]);
    else n_pass++;
    n_total++; if (payload_out[13:12] !== TrNseq)
      $display("FAIL single_htrans got %b want 10", payload_out[13:12]);
    else n_pass++;
    n_total++; if (payload_out[45:14] !== 32'h0)
      $display("FAIL single_hwdata_addr_phase got %h want 0", payload_out[45:14]);
    else n_pass++;
    tick();
    n_total++; if (resp_sel !== 2'b01) $display("FAIL single_resp_sel got %b want 01", resp_sel);
    else n_pass++;
    n_total++; if (payload_out[45:14] !== 32'hA5A5_0001)
      $display("FAIL single_hwdata got %h want a5a50001", payload_out[45:14]);
    else n_pass++;
  endtask

  task automatic test_contention();
    logic [1:0] exp_g [4];
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    do_reset();
    payload_in[0] = mk(32'h0000_2000, 32'hC0C0_0000, TrNseq, 1'b0);
    payload_in[1] = mk(32'h0000_3000, 32'hC1C1_1111, TrNseq, 1'b0);
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_total++; if (grant !== exp_g[i])
        $display("FAIL contention_grant[%0d] got %b want %b", i, grant, exp_g[i]);
      else n_pass++;
      if (i > 0) begin
        n_total++; if (resp_sel !== exp_g[i-1])
          $display("FAIL contention_resp_sel[%0d] got %b want %b", i, resp_sel, exp_g[i-1]);
        else n_pass++;
        n_total++; if (payload_out[45:14] !== ((exp_g[i-1] == 2'b01) ? 32'hC0C0_0000
                                                                      : 32'hC1C1_1111))
          $display("FAIL contention_hwdata[%0d] got %h", i, payload_out[45:14]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_locked_burst();
    do_reset();
    payload_in[0] = mk(32'h0000_0100, 32'hB000_0000, TrNseq, 1'b1);
    payload_in[1] = mk(32'h0000_9000, 32'hD000_0000, TrNseq, 1'b0);
    req = 2'b11;
    tick();
    n_total++; if (grant !== 2'b01) $display("FAIL burst_beat0_grant got %b want 01", grant);
    else n_pass++;
    for (int b = 1; b < 4; b++) begin
      tick();
      n_total++; if (grant !== 2'b01)
        $display("FAIL burst_beat%0d_grant got %b want 01", b, grant);
      else n_pass++;
      n_total++; if (resp_sel !== 2'b01)
        $display("FAIL burst_beat%0d_resp_sel got %b want 01", b, resp_sel);
      else n_pass++;
      payload_in[0] = mk(32'h0000_0100 + 32'(4 * b), 32'hB000_0000 + 32'(b), TrSeq, 1'b0);
      if (b == 2) begin
        hreadyout = 1'b0;
        for (int w = 0; w < 3; w++) begin
          tick();
          n_total++; if (grant !== 2'b01 || resp_sel !== 2'b01)
            $display("FAIL wait%0d_state got grant %b resp %b want 01 01", w, grant, resp_sel);
          else n_pass++;
          n_total++; if (payload_out[77:46] !== 32'h0000_0108 || payload_out[13:12] !== TrSeq)
            $display("FAIL wait%0d_addr got %h/%b want 00000108/11", w,
                     payload_out[77:46], payload_out[13:12]);
          else n_pass++;
        end
        hreadyout = 1'b1;
      end
    end
    tick();
    n_total++; if (grant !== 2'b01) $display("FAIL burst_last_seq_grant got %b want 01", grant);
    else n_pass++;
    n_total++; if (payload_out[45:14] !== 32'hB000_0003)
      $display("FAIL burst_last_hwdata got %h want b0000003", payload_out[45:14]);
    else n_pass++;
    payload_in[0] = mk(32'h0000_0110, 32'hB000_0004, TrIdle, 1'b0);
    tick();
    n_total++; if (grant !== 2'b10) $display("FAIL burst_handover_grant got %b want 10", grant);
    else n_pass++;
    n_total++; if (resp_sel !== 2'b00)
      $display("FAIL burst_handover_resp_sel got %b want 00", resp_sel);
    else n_pass++;
    n_total++; if (payload_out[77:46] !== 32'h0000_9000)
      $display("FAIL burst_handover_haddr got %h want 00009000", payload_out[77:46]);
    else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    payload_in[0] = mk(32'h0000_0200, 32'hE000_0000, TrNseq, 1'b1);
    req = 2'b01;
    tick();
    payload_in[0] = mk(32'h0000_0204, 32'hE000_0001, TrSeq, 1'b0);
    tick();
    n_total++; if (grant !== 2'b01 || resp_sel !== 2'b01)
      $display("FAIL midrst_pre got grant %b resp %b want 01 01", grant, resp_sel);
    else n_pass++;
    #2;
    HRESETn = 1'b0;
    #1;
    n_total++; if (grant !== 2'b00 || resp_sel !== 2'b00)
      $display("FAIL midrst_state got grant %b resp %b want 00 00", grant, resp_sel);
    else n_pass++;
    n_total++; if (payload_out !== 78'd0 || hsel_out !== 1'b0)
      $display("FAIL midrst_outputs got %h hsel %b want 0 0", payload_out, hsel_out);
    else n_pass++;
    tick();
    HRESETn = 1'b1;
    payload_in[0] = mk(32'h0000_0300, 32'h0, TrNseq, 1'b0);
    payload_in[1] = mk(32'h0000_0400, 32'h0, TrNseq, 1'b0);
    req = 2'b11;
    tick();
    n_total++; if (grant !== 2'b01) $display("FAIL midrst_restart got %b want 01", grant);
    else n_pass++;
  endtask

  task automatic test_idle_release();
    do_reset();
    payload_in[1] = mk(32'h0000_0500, 32'h5555_0000, TrNseq, 1'b0);
    req = 2'b10;
    tick();
    n_total++; if (grant !== 2'b10) $display("FAIL idle_grant got %b want 10", grant);
    else n_pass++;
    payload_in[1] = mk(32'h0000_0500, 32'h5555_0000, TrIdle, 1'b0);
    req = 2'b00;
    tick();
    n_total++; if (grant !== 2'b00 || resp_sel !== 2'b00)
      $display("FAIL idle_release got grant %b resp %b want 00 00", grant, resp_sel);
    else n_pass++;
    n_total++; if (payload_out !== 78'd0)
      $display("FAIL idle_payload got %h want 0", payload_out);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_locked_burst();
    test_reset_mid_burst();
    test_idle_release();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
